vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters:
  - the VGA display fetch path, driven by `need` and the frame-end pulse from the VGA timing controller;
  - a drawing engine using a req/ack handshake.
- Display fetch has absolute priority. It must never miss a pixel.
- The drawer is served only in cycles where `need` is low, i.e. during blanking and the single gap cycles.
- The block owns the linear display address counter, so no vertical × horizontal multiply is needed downstream.

Parameters:
- AW, 19, RAM address width (800x600 = 480000 words).
- DW, 8, pixel/data width.
- FB_WORDS, 480000, words per frame; the display address wraps here.
- STARVE_MAX, 1024, consecutive drawer wait cycles before `drw_starve` asserts.

Ports:
- `clk` in 1: pixel clock, same clock as the VGA timing controller.
- `reset_` in 1: asynchronous active-low reset.
- `need` in 1: display requires one pixel fetch this cycle.
- `frame_end` in 1: one-cycle pulse at end of vertical period (`vEnd`).
- `pix_valid` out 1: `pix_data` is valid this cycle.
- `pix_data` out DW: fetched pixel.
- `drw_req` in 1: drawer request; held until acked.
- `drw_we` in 1: 1 = write, 0 = read.
- `drw_addr` in AW: drawer address.
- `drw_wdata` in DW: drawer write data.
- `drw_ack` out 1: request accepted this cycle (combinational).
- `drw_rvalid` out 1: drawer read data valid.
- `drw_rdata` out DW: drawer read data.
- `drw_starve` out 1: drawer has waited ≥ STARVE_MAX cycles.
- `mem_addr` out AW: RAM address (registered).
- `mem_we` out 1: RAM write enable (registered).
- `mem_wdata` out DW: RAM write data (registered).
- `mem_rdata` in DW: RAM read data, valid one cycle after the address.

Behaviour:
- **Reset.** `reset_` low asynchronously clears all registers:
  - `disp_addr` = 0; `mem_addr` = 0; `mem_we` = 0; `mem_wdata` = 0;
  - `pix_valid` = 0; `drw_rvalid` = 0; `drw_starve` = 0;
  - starve counter = 0; read-tag pipeline = IDLE.
  - `drw_ack` = 0 while in reset.
  - Reset mid-transaction drops in-flight reads silently; no valid pulse is issued afterward.
- **Grant, cycle N.** `need`=1 → display granted. Otherwise `drw_req`=1 → drawer granted and `drw_ack`=1 in N. Otherwise idle (`mem_we`=0, `mem_addr` held).
- **Issue, edge N→N+1.**
  - Display grant: `mem_addr` ← `disp_addr`, `mem_we` ← 0, `disp_addr` ← `disp_addr`+1.
  - Drawer grant: `mem_addr` ← `drw_addr`, `mem_we` ← `drw_we`, `mem_wdata` ← `drw_wdata`.
- **Read-tag pipeline.** Two stages, tags {IDLE, DISP, DRAW}. The tag is captured with the issue and retired two cycles after grant.
  - `pix_valid`=1 in N+2 iff the tag is DISP; `pix_data` = `mem_rdata` that cycle.
  - `drw_rvalid`=1 in N+2 iff the tag is DRAW and it was a read; `drw_rdata` = `mem_rdata`.
  - Fixed latency: 2 cycles from `need` to pixel. Back-to-back issue every cycle is allowed.
- **Drawer handshake.**
  - The drawer may present a new request in N+1 after `drw_ack`.
  - Inputs must be stable while `drw_req`=1 and unacked.
  - Writes produce no `drw_rvalid`.
- **Address wrap.** `disp_addr` wraps FB_WORDS-1 → 0.
- **Frame end.**
  - `frame_end`=1 forces `disp_addr` ← 0 at the next edge and overrides the wrap.
  - If `need` and `frame_end` are both 1, the fetch uses the current `disp_addr`, then the counter loads 0, not +1.
- **Starve counter.**
  - Increments when `drw_req`=1 and `drw_ack`=0, saturating at STARVE_MAX.
  - Clears when `drw_ack`=1 or `drw_req`=0.
  - `drw_starve` = (count ≥ STARVE_MAX), registered. It is advisory only and never overrides display priority.
- **Simultaneous `need` and `drw_req`.** Display wins and `drw_ack`=0; the drawer stays pending.

Optional Feature:
- Macro: `VGA_FB_DOUBLE_BUFFER_EN`.
- When defined:
  - Adds input `swap_req` (1-bit level) and output `front_sel` (1-bit).
  - A `swap_req` seen high sets a pending flag.
  - At the next `frame_end`, `front_sel` toggles and the pending flag clears.
  - Display addresses = `front_sel`·FB_WORDS + `disp_addr`; drawer addresses = (!`front_sel`)·FB_WORDS + `drw_addr`. AW must cover 2·FB_WORDS.
  - Reset: `front_sel`=0, pending=0.
- When undefined: single buffer; addresses as described above; no extra ports.

Decomposition:
- Shared package `vga_pkg`:
  - tag encoding constants TAG_IDLE=0, TAG_DISP=1, TAG_DRAW_RD=2, TAG_DRAW_WR=3;
  - 800x600 frame constants (HC=800, VC=600, FB_WORDS).
- Sub-module `vga_fb_addr_counter`: display address counter with wrap, `frame_end` load and optional bank offset.
- Grant logic, tag pipeline and starve counter stay in the top module.

Test Plan:
- **Reset/idle.** `reset_` low mid-stream, all inputs 0 → all outputs 0; no `pix_valid` or `drw_rvalid` pulse after release.
- **Display stream.** `need`=1 for 800 cycles from reset → `mem_addr` 0..799 on consecutive cycles starting at cycle 1; `pix_valid` high on cycles 2..801; `pix_data` matches the RAM model.
- **Contention.** `need`=1 with `drw_req`=1 for 10 cycles, then `need`=0 → `drw_ack`=0 for 10 cycles, `drw_starve`=0 (STARVE_MAX=1024); ack in cycle 10; a read at `drw_addr`=0x1234 returns `drw_rvalid` in cycle 12.
- **Starvation.** STARVE_MAX=4, `need`=1 held, `drw_req`=1 → `drw_starve` rises after 4 wait cycles; clears the cycle after ack.
- **Frame end.** `disp_addr`=479999 with `need` and `frame_end` together → fetch 479999; next fetch is address 0. Separately, `need` at 479999 without `frame_end` → next fetch is 0.
- **Double buffer (`VGA_FB_DOUBLE_BUFFER_EN`).** `swap_req` pulse mid-frame → `front_sel` unchanged until `frame_end`, then 1; display addresses start at 480000; drawer writes to `drw_addr` 0 go to RAM address 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared 800x600 frame constants and read-tag encoding for the framebuffer arbiter.
// VGA_FB_DOUBLE_BUFFER_EN widens the default address to cover two frames.
package vga_pkg;
  localparam int HC = 800;
  localparam int VC = 600;
  localparam int FB_WORDS = HC * VC;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
  localparam int DEF_AW = 20;
`else
  localparam int DEF_AW = 19;
`endif
  typedef enum logic [1:0] {
    TAG_IDLE    = 2'd0,
    TAG_DISP    = 2'd1,
    TAG_DRAW_RD = 2'd2,
    TAG_DRAW_WR = 2'd3
  } tag_e;
endpackage

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: drawer handshake plus framebuffer RAM port.
// master = drawer/RAM side, slave = arbiter.
interface vga_fb_arbiter_if import vga_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = 8
);
  logic          drw_req;
  logic          drw_we;
  logic [AW-1:0] drw_addr;
  logic [DW-1:0] drw_wdata;
  logic          drw_ack;
  logic          drw_rvalid;
  logic [DW-1:0] drw_rdata;
  logic          drw_starve;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport master (
    output drw_req, drw_we, drw_addr, drw_wdata, mem_rdata,
    input  drw_ack, drw_rvalid, drw_rdata, drw_starve, mem_addr, mem_we, mem_wdata
  );
  modport slave (
    input  drw_req, drw_we, drw_addr, drw_wdata, mem_rdata,
    output drw_ack, drw_rvalid, drw_rdata, drw_starve, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_fb_addr_counter.sv
// vga_fb_addr_counter: linear display address with wrap at FB_WORDS, frame_end reload
// and an optional bank offset selecting the second frame.
module vga_fb_addr_counter #(
  parameter int AW = 19,
  parameter int FB_WORDS = 480000
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          adv,
  input  logic          frame_end,
  input  logic          bank,
  output logic [AW-1:0] addr
);
  logic [AW-1:0] disp_q, disp_d;
  // frame_end wins over both the increment and the wrap
  always_comb disp_d = frame_end ? '0 : !adv ? disp_q : disp_q == AW'(FB_WORDS - 1) ? '0 : disp_q + 1'b1;
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) disp_q <= '0;
    else disp_q <= disp_d;
  assign addr = (bank ? AW'(FB_WORDS) : '0) + disp_q;
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer arbiter, display fetch has absolute priority over the drawer.
// VGA_FB_DOUBLE_BUFFER_EN adds swap_req/front_sel page flipping at frame_end.
module vga_fb_arbiter import vga_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = 8,
  parameter int FB_WORDS = vga_pkg::FB_WORDS,
  parameter int STARVE_MAX = 1024
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          need,
  input  logic          frame_end,
`ifdef VGA_FB_DOUBLE_BUFFER_EN
  input  logic          swap_req,
  output logic          front_sel,
`endif
  output logic          pix_valid,
  output logic [DW-1:0] pix_data,
  vga_fb_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic          drw_gnt, bank, starve_q, starve_d, mem_we_q, mem_we_d;
  logic [AW-1:0] disp_addr, drw_base, mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [SW-1:0] cnt_q, cnt_d;
  tag_e          tag1_q, tag1_d, tag2_q;

`ifdef VGA_FB_DOUBLE_BUFFER_EN
  logic front_q, front_d, pend_q, pend_d;
  always_comb begin
    pend_d  = frame_end ? 1'b0 : pend_q | swap_req;
    front_d = front_q ^ (frame_end & pend_q);
  end
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      front_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      front_q <= front_d;
      pend_q  <= pend_d;
    end
  assign front_sel = front_q;
  assign bank      = front_q;
  // drawer always targets the back buffer
  assign drw_base  = front_q ? '0 : AW'(FB_WORDS);
`else
  assign bank     = 1'b0;
  assign drw_base = '0;
`endif

  vga_fb_addr_counter #(.AW(AW), .FB_WORDS(FB_WORDS)) u_cnt (
    .clk(clk), .reset_(reset_), .adv(need), .frame_end(frame_end), .bank(bank), .addr(disp_addr)
  );

  always_comb begin
    drw_gnt     = reset_ & ~need & bus.drw_req;
    mem_addr_d  = need ? disp_addr : drw_gnt ? drw_base + bus.drw_addr : mem_addr_q;
    mem_we_d    = drw_gnt & bus.drw_we;
    mem_wdata_d = drw_gnt ? bus.drw_wdata : mem_wdata_q;
    tag1_d      = need ? TAG_DISP : !drw_gnt ? TAG_IDLE : bus.drw_we ? TAG_DRAW_WR : TAG_DRAW_RD;
    cnt_d       = (bus.drw_req & ~drw_gnt) ? (cnt_q == SW'(STARVE_MAX) ? cnt_q : cnt_q + 1'b1) : '0;
    starve_d    = cnt_d >= SW'(STARVE_MAX);
  end

  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      tag1_q      <= TAG_IDLE;
      tag2_q      <= TAG_IDLE;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
    end

  assign bus.drw_ack    = drw_gnt;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.drw_starve = starve_q;
  assign pix_valid      = tag2_q == TAG_DISP;
  assign pix_data       = bus.mem_rdata;
  assign bus.drw_rvalid = tag2_q == TAG_DRAW_RD;
  assign bus.drw_rdata  = bus.mem_rdata;
endmodule
